// File: rtl/pipe_ctrl.sv
// Pipeline hazard/halt controller: load-use stall, branch flush, halt/drain/single-step
// sequencing, and saturating stall/flush event counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rt_used,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_br_taken,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2,
        S_STEP   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       DRAIN_LEN = 3'd4;

    state_e           state_q, state_d;
    logic [2:0]       drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic hazard;
    logic stall_ev;
    logic flush_ev;

    always_comb begin
        hazard = ex_memread && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_rt_used && (ex_rt == id_rt)));
    end

    // A taken branch supersedes a load-use stall, so that cycle is a flush, not a stall.
    always_comb begin
        stall_ev = ((state_q == S_RUN) || (state_q == S_DRAIN)) && hazard && !mem_br_taken;
        flush_ev = mem_br_taken && (state_q != S_HALTED);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LEN;
                end
            end
            S_DRAIN: begin
                if (!halt_req) begin
                    state_d = S_RUN;
                end else if (mem_br_taken) begin
                    // Branch target was just captured; give it a full drain window.
                    drain_d = DRAIN_LEN;
                end else if (!hazard) begin
                    if (drain_q <= 3'd1) begin
                        drain_d = '0;
                        state_d = S_HALTED;
                    end else begin
                        drain_d = drain_q - 3'd1;
                    end
                end
            end
            S_HALTED: begin
                if (!halt_req) begin
                    state_d = S_RUN;
                end else if (step_req) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (!halt_req) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LEN;
                end
            end
            default: begin
                state_d = S_RUN;
                drain_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_ev && (stall_q != '1)) begin
            stall_d = stall_q + CNT_ONE;
        end
        if (flush_ev && (flush_q != '1)) begin
            flush_d = flush_q + CNT_ONE;
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halted      = 1'b0;
        if (RST) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            unique case (state_q)
                S_HALTED: begin
                    halted = 1'b1;
                end
                S_RUN, S_DRAIN, S_STEP: begin
                    if (mem_br_taken) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (hazard && (state_q != S_STEP)) begin
                        idex_flush = 1'b1;
                    end else if (state_q == S_DRAIN) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model; a narrow-counter instance exercises saturation.
module tb_pipe_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_rt_used, ex_memread, mem_br_taken, halt_req, step_req;

    logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_en_s, ifid_en_s, ifid_flush_s, idex_flush_s, exmem_flush_s, halted_s;
    logic [3:0]  stall_cnt_s, flush_cnt_s;

    logic [5:0]  obs, obs_s;
    assign obs   = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, halted};
    assign obs_s = {pc_en_s, ifid_en_s, ifid_flush_s, idex_flush_s, exmem_flush_s, halted_s};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    pipe_ctrl #(.CNT_W(16)) u_dut (
        .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_br_taken(mem_br_taken),
        .halt_req(halt_req), .step_req(step_req), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_sat (
        .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_br_taken(mem_br_taken),
        .halt_req(halt_req), .step_req(step_req), .pc_en(pc_en_s), .ifid_en(ifid_en_s),
        .ifid_flush(ifid_flush_s), .idex_flush(idex_flush_s), .exmem_flush(exmem_flush_s),
        .halted(halted_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    // Behavioural model: pipeline mode, remaining drain cycles, unbounded event totals.
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_STEP = 3;
    int     m_mode = M_RUN;
    int     m_left = 0;
    longint m_stalls = 0;
    longint m_flushes = 0;

    function automatic bit load_use();
        return ex_memread && ex_rt != 0 &&
               (ex_rt == id_rs || (id_rt_used && ex_rt == id_rt));
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, halted}
    function automatic logic [5:0] exp_out();
        if (RST)                 return 6'b001110;
        if (m_mode == M_HALTED)  return 6'b000001;
        if (mem_br_taken)        return 6'b111110;
        if (load_use() && m_mode != M_STEP) return 6'b000100;
        if (m_mode == M_DRAIN)   return 6'b011000;
        return 6'b110000;
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        if (v >= 65535) return 16'hFFFF;
        return 16'(v);
    endfunction

    function automatic logic [3:0] sat4(input longint v);
        if (v >= 15) return 4'hF;
        return 4'(v);
    endfunction

    // Advance one clock; the model consumes the inputs present during the closing cycle.
    task automatic tick();
        int     nm = m_mode;
        int     nl = m_left;
        longint ns = m_stalls;
        longint nf = m_flushes;
        if (RST) begin
            nm = M_RUN; nl = 0; ns = 0; nf = 0;
        end else begin
            if ((m_mode == M_RUN || m_mode == M_DRAIN) && load_use() && !mem_br_taken) ns++;
            if (mem_br_taken && m_mode != M_HALTED) nf++;
            case (m_mode)
                M_RUN:    if (halt_req) begin nm = M_DRAIN; nl = 4; end
                M_DRAIN: begin
                    if (!halt_req) nm = M_RUN;
                    else if (mem_br_taken) nl = 4;
                    else if (!load_use()) begin
                        nl = m_left - 1;
                        if (nl == 0) nm = M_HALTED;
                    end
                end
                M_HALTED: begin
                    if (!halt_req) nm = M_RUN;
                    else if (step_req) nm = M_STEP;
                end
                default: begin
                    if (!halt_req) nm = M_RUN;
                    else begin nm = M_DRAIN; nl = 4; end
                end
            endcase
        end
        @(posedge CLK);
        m_mode = nm; m_left = nl; m_stalls = ns; m_flushes = nf;
        #1;
    endtask

    task automatic set_idle();
        id_rs = 5'd1; id_rt = 5'd2; id_rt_used = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0;
        mem_br_taken = 1'b0; step_req = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; halt_req = 1'b0; set_idle();
        ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; mem_br_taken = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b001110) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 001110", obs);
        end
        tick(); tick();
        @(negedge CLK);
        n_tests++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || stall_cnt_s !== 4'd0 || flush_cnt_s !== 4'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d/%0d want all 0",
                               stall_cnt, flush_cnt, stall_cnt_s, flush_cnt_s);
        end
        tick();
        RST = 1'b0; set_idle();
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b110000) begin
            n_fail++; $display("FAIL post_reset_run: got %b want 110000", obs);
        end
        tick();
    endtask

    task automatic test_load_use();
        set_idle(); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b000100) begin
            n_fail++; $display("FAIL load_use_stall: got %b want 000100", obs);
        end
        tick(); set_idle();
        @(negedge CLK);
        n_tests++;
        if (stall_cnt !== 16'd1 || obs !== 6'b110000) begin
            n_fail++; $display("FAIL load_use_after: got cnt=%0d out=%b want cnt=1 out=110000", stall_cnt, obs);
        end
        tick();
    endtask

    task automatic test_false_hazard();
        set_idle(); ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b110000) begin
            n_fail++; $display("FAIL false_hazard_r0: got %b want 110000", obs);
        end
        tick();
        set_idle(); ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rt_used = 1'b0;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b110000) begin
            n_fail++; $display("FAIL false_hazard_rt_unused: got %b want 110000", obs);
        end
        tick();
        id_rt_used = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (stall_cnt !== 16'd1 || obs !== 6'b000100) begin
            n_fail++; $display("FAIL rt_hazard: got cnt=%0d out=%b want cnt=1 out=000100", stall_cnt, obs);
        end
        tick(); set_idle();
        @(negedge CLK);
        n_tests++;
        if (stall_cnt !== 16'd2) begin
            n_fail++; $display("FAIL rt_hazard_count: got %0d want 2", stall_cnt);
        end
        tick();
    endtask

    task automatic test_branch_hazard();
        set_idle(); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; mem_br_taken = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b111110) begin
            n_fail++; $display("FAIL branch_hazard_out: got %b want 111110", obs);
        end
        tick(); set_idle();
        @(negedge CLK);
        n_tests++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
            n_fail++; $display("FAIL branch_hazard_cnt: got flush=%0d stall=%0d want 1/2", flush_cnt, stall_cnt);
        end
        tick();
    endtask

    task automatic test_halt_drain();
        set_idle(); halt_req = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b110000) begin
            n_fail++; $display("FAIL halt_run_cycle: got %b want 110000", obs);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_tests++;
            if (obs !== 6'b011000) begin
                n_fail++; $display("FAIL drain_cycle%0d: got %b want 011000", i, obs);
            end
            tick();
        end
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b000001) begin
            n_fail++; $display("FAIL halted_reached: got %b want 000001", obs);
        end
        tick();
    endtask

    task automatic test_step();
        step_req = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b000001) begin
            n_fail++; $display("FAIL step_req_cycle: got %b want 000001", obs);
        end
        tick(); step_req = 1'b0;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b110000) begin
            n_fail++; $display("FAIL step_issue: got %b want 110000", obs);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_tests++;
            if (obs !== 6'b011000) begin
                n_fail++; $display("FAIL step_drain%0d: got %b want 011000", i, obs);
            end
            tick();
        end
        halt_req = 1'b0;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b000001) begin
            n_fail++; $display("FAIL step_rehalted: got %b want 000001", obs);
        end
        tick(); step_req = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b110000) begin
            n_fail++; $display("FAIL resume_run: got %b want 110000", obs);
        end
        tick();
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b110000) begin
            n_fail++; $display("FAIL step_ignored_in_run: got %b want 110000", obs);
        end
        tick(); set_idle();
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            set_idle(); ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
            tick();
        end
        set_idle(); halt_req = 1'b1;
        tick();
        @(negedge CLK);
        n_tests++;
        if (stall_cnt !== 16'd5 || obs !== 6'b011000) begin
            n_fail++; $display("FAIL pre_reset_drain: got cnt=%0d out=%b want 5/011000", stall_cnt, obs);
        end
        tick(); RST = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b001110) begin
            n_fail++; $display("FAIL mid_drain_reset_out: got %b want 001110", obs);
        end
        tick(); RST = 1'b0;
        @(negedge CLK);
        n_tests++;
        if (obs !== 6'b110000 || stall_cnt !== 16'd0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL mid_drain_reset_after: got out=%b cnt=%0d want 110000/0", obs, stall_cnt);
        end
        halt_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            RST          = ($urandom_range(63, 0) == 0);
            if ($urandom_range(11, 0) == 0) halt_req = ~halt_req;
            step_req     = ($urandom_range(5, 0) == 0);
            id_rs        = 5'($urandom_range(3, 0));
            id_rt        = 5'($urandom_range(3, 0));
            ex_rt        = 5'($urandom_range(3, 0));
            id_rt_used   = 1'($urandom_range(1, 0));
            ex_memread   = 1'($urandom_range(1, 0));
            mem_br_taken = ($urandom_range(7, 0) == 0);
            @(negedge CLK);
            n_tests++;
            if (obs !== exp_out() || obs_s !== exp_out()) begin
                n_fail++; $display("FAIL rand_out[%0d]: got %b/%b want %b", i, obs, obs_s, exp_out());
            end
            n_tests++;
            if (stall_cnt !== sat16(m_stalls) || flush_cnt !== sat16(m_flushes)) begin
                n_fail++; $display("FAIL rand_cnt16[%0d]: got %0d/%0d want %0d/%0d", i,
                                   stall_cnt, flush_cnt, sat16(m_stalls), sat16(m_flushes));
            end
            n_tests++;
            if (stall_cnt_s !== sat4(m_stalls) || flush_cnt_s !== sat4(m_flushes)) begin
                n_fail++; $display("FAIL rand_cnt4[%0d]: got %0d/%0d want %0d/%0d", i,
                                   stall_cnt_s, flush_cnt_s, sat4(m_stalls), sat4(m_flushes));
            end
            tick();
        end
        RST = 1'b0; halt_req = 1'b0; set_idle();
    endtask

    task automatic test_saturation();
        RST = 1'b1; tick(); RST = 1'b0;
        set_idle(); halt_req = 1'b0; mem_br_taken = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        @(negedge CLK);
        n_tests++;
        if (flush_cnt !== 16'hFFFE || flush_cnt_s !== 4'hF) begin
            n_fail++; $display("FAIL flush_near_sat: got %h/%h want FFFE/F", flush_cnt, flush_cnt_s);
        end
        for (int i = 0; i < 4; i++) tick();
        @(negedge CLK);
        n_tests++;
        if (flush_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL flush_saturate: got %h want FFFF", flush_cnt);
        end
        set_idle(); ex_memread = 1'b1; ex_rt = 5'd6; id_rs = 5'd6;
        for (int i = 0; i < 20; i++) tick();
        @(negedge CLK);
        n_tests++;
        if (stall_cnt_s !== 4'hF || stall_cnt !== 16'd20 || flush_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL stall_saturate: got %h/%0d/%h want F/20/FFFF",
                               stall_cnt_s, stall_cnt, flush_cnt);
        end
        set_idle(); tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_false_hazard();
        test_branch_hazard();
        test_halt_drain();
        test_step();
        test_reset_mid_drain();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the event counters.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port id_rs  input  5  rs field of instruction in IF/ID.
REQ-005 SHALL have port id_rt  input  5  rt field of instruction in IF/ID.
REQ-006 SHALL have port id_rt_used  input  1  ID instruction reads rt (R-type, sw, beq).
REQ-007 SHALL have port ex_memread  input  1  instruction in ID/EX is a load.
REQ-008 SHALL have port ex_rt  input  5  destination rt of instruction in ID/EX.
REQ-009 SHALL have port mem_br_taken  input  1  branch in EX/MEM taken (Branch AND zero flag).
REQ-010 SHALL have port halt_req  input  1  level; 1 = halt pipeline, 0 = run.
REQ-011 SHALL have port step_req  input  1  single-cycle pulse; issue one instruction while halted.
REQ-012 SHALL have port pc_en  output  1  PC load enable.
REQ-013 SHALL have port ifid_en  output  1  IF/ID load enable (0 = hold).
REQ-014 SHALL have port ifid_flush  output  1  load bubble (all zero) into IF/ID.
REQ-015 SHALL have port idex_flush  output  1  load bubble (control zero) into ID/EX.
REQ-016 SHALL have port exmem_flush  output  1  load bubble (control zero) into EX/MEM.
REQ-017 SHALL have port halted  output  1  pipeline drained and stopped.
REQ-018 SHALL have port stall_cnt  output  CNT_W  load-use stall cycles.
REQ-019 SHALL have port flush_cnt  output  CNT_W  branch flush events.

Function
REQ-020 SHALL implement states RUN, DRAIN, HALTED, STEP plus a 3-bit drain counter; control outputs combinational from state and current inputs.
REQ-021 hazard = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_rt_used & ex_rt==id_rt)).
REQ-022 RUN, no event: pc_en=1, ifid_en=1, all flushes 0.
REQ-023 hazard (RUN or DRAIN, no branch): pc_en=0, ifid_en=0, idex_flush=1 same cycle; exactly one bubble per load.
REQ-024 mem_br_taken (any state except HALTED): pc_en=1, ifid_flush=idex_flush=exmem_flush=1 same cycle; overrides hazard; hazard not counted.
REQ-025 RUN & halt_req=1 -> DRAIN next cycle, drain counter loaded 4; outputs that cycle per RUN rules.
REQ-026 DRAIN: pc_en=0, ifid_flush=1 unless hazard (hold instead); counter decrements per cycle without hazard; counter reaching 0 -> HALTED.
REQ-027 DRAIN & mem_br_taken: pc_en=1 (target captured), counter reloaded 4.
REQ-028 HALTED: pc_en=0, ifid_en=0, flushes 0, halted=1; halt_req=0 -> RUN (priority over step_req); step_req=1 -> STEP.
REQ-029 STEP: one cycle pc_en=1, ifid_en=1, then DRAIN with counter 4; halt_req=0 during STEP -> RUN instead.
REQ-030 halted=1 only in HALTED.
REQ-031 stall_cnt +1 per cycle with REQ-023 stall; flush_cnt +1 per mem_br_taken cycle; both saturate at all ones, never wrap.
REQ-032 step_req ignored outside HALTED; halt_req=0 in DRAIN -> RUN next cycle.

Reset
REQ-033 RST=1 at clock edge: state RUN, drain counter 0, stall_cnt=0, flush_cnt=0; overrides all inputs and any state.
REQ-034 while RST=1: pc_en=0, ifid_en=0, ifid_flush=idex_flush=exmem_flush=1, halted=0.
REQ-035 first cycle after RST falls: RUN outputs per REQ-022.

Verification
REQ-036 load-use: ex_memread=1, ex_rt=8, id_rs=8 one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt 0->1.
REQ-037 false hazard: ex_rt=0=id_rs, or ex_rt=9=id_rt with id_rt_used=0 -> no stall, stall_cnt unchanged.
REQ-038 branch+hazard same cycle -> all three flushes 1, pc_en=1, flush_cnt+1, stall_cnt unchanged.
REQ-039 halt_req=1 in RUN, no events -> 1 RUN cycle, 4 DRAIN cycles (pc_en=0, ifid_flush=1), then halted=1.
REQ-040 HALTED, step_req pulse -> 1 cycle pc_en=1/ifid_en=1, 4 DRAIN cycles, halted=1 again; halt_req=0 -> RUN next cycle.
REQ-041 RST=1 mid-DRAIN with stall_cnt=5 -> next cycle RUN, stall_cnt=0, halted=0; counters saturate at 0xFFFF with forced events.
